// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte request/status handshake between a command source
// and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, busy, tx_done, tx_error
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, busy, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter on open-drain
// ps2c/ps2d. Sequence: clock inhibit, start request, d0..d7, odd parity,
// stop, device ack. The oe outputs only ever pull a pin low.
// Optional macro PS2_TX_TIMEOUT_EN adds a watchdog that aborts a stalled
// transfer TIMEOUT_CYCLES after acceptance.
module ps2_host_tx #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 16,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 750_000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus,
    input  logic         ps2c_in,
    input  logic         ps2d_in,
    output logic         ps2c_oe,
    output logic         ps2d_oe
);

    localparam int FW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TMAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
    } state_t;

    // CLK_HZ is informational; folded here so it is visibly consumed.
    logic unused_params;
    assign unused_params = ^{32'(CLK_HZ), 32'(TIMEOUT_CYCLES)};

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]    meta_q, sync_q, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          fall_c_q;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q;
    logic [3:0]    bit_cnt_q;
    logic [8:0]    frame_q;
    logic          d_oe_q;
    logic          err_q;
    logic          accept, lines_high, timeout;

    // Synchronize both pins and debounce them; strobe fall_c on a filtered 1->0 of ps2c.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q   <= '1;
            sync_q   <= '1;
            filt_q   <= '1;
            fall_c_q <= 1'b0;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here sample the
            // previous-cycle value, so meta->sync->filter is a true pipeline.
            meta_q   <= {ps2d_in, ps2c_in};
            sync_q   <= meta_q;
            fall_c_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync_q[i];
                    fcnt_q[i] <= '0;
                    if (i == 0 && !sync_q[i]) fall_c_q <= 1'b1;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign lines_high   = filt_q[0] & filt_q[1];
    assign bus.tx_ready = (state_q == S_IDLE) && lines_high;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.tx_error = err_q;
    assign accept       = bus.tx_valid && bus.tx_ready;

`ifdef PS2_TX_TIMEOUT_EN
    logic [19:0] wd_q;

    // Watchdog: counts cycles since acceptance, saturating.
    always_ff @(posedge clk) begin
        if (rst)               wd_q <= '0;
        else if (accept)       wd_q <= '0;
        else if (wd_q != '1)   wd_q <= wd_q + 1'b1;
    end

    assign timeout = (state_q != S_IDLE) && (wd_q >= 20'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and pin/pulse outputs decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        ps2c_oe     = 1'b0;
        ps2d_oe     = 1'b0;
        bus.tx_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_INHIBIT;
            end
            S_INHIBIT: begin
                ps2c_oe = 1'b1;
                if (tmr_q == TW'(INHIBIT_CYCLES - 1)) state_d = S_REQ;
            end
            S_REQ: begin
                ps2c_oe = 1'b1;
                ps2d_oe = 1'b1;
                if (tmr_q == TW'(REQ_CYCLES - 1)) state_d = S_SEND;
            end
            S_SEND: begin
                ps2d_oe = d_oe_q;
                if (fall_c_q && bit_cnt_q == 4'd9) state_d = S_ACK;
            end
            S_ACK: begin
                if (fall_c_q) state_d = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (lines_high) begin
                    bus.tx_done = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timeout) begin
            ps2c_oe     = 1'b0;
            ps2d_oe     = 1'b0;
            bus.tx_done = 1'b1;
            state_d     = S_IDLE;
        end
    end

    // Datapath: phase timer, frame latch, bit shifting on fall_c, ack/error status.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            d_oe_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tmr_q <= (state_d != state_q) ? '0 : tmr_q + 1'b1;
            if (accept) begin
                frame_q   <= {~^bus.tx_data, bus.tx_data};
                bit_cnt_q <= '0;
                err_q     <= 1'b0;
            end
            // Start bit: data stays low when the clock is released.
            if (state_q == S_REQ) d_oe_q <= 1'b1;
            if (state_q == S_SEND && fall_c_q) begin
                if (bit_cnt_q != 4'd9) begin
                    d_oe_q    <= ~frame_q[bit_cnt_q];
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end else begin
                    d_oe_q <= 1'b0;
                end
            end
            if (state_q == S_ACK && fall_c_q && filt_q[1]) err_q <= 1'b1;
            if (timeout) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model
// that clocks the frame, samples data on rising edges and optionally acks.
module tb_ps2_host_tx;

    localparam int HALF = 50;     // device clock half-period in system cycles
    localparam int TMO  = 30000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();
    logic ps2c_oe, ps2d_oe;
    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    logic ps2c_line, ps2d_line;
    assign ps2c_line = ~(ps2c_oe | dev_c_low);
    assign ps2d_line = ~(ps2d_oe | dev_d_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(5000),
        .REQ_CYCLES    (16),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .ps2c_in(ps2c_line),
        .ps2d_in(ps2d_line),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int oe_run = 0;
    int last_run = 0;
    int base;
    logic [10:0] bits, bits2;

    // Count tx_done pulses and measure the length of each ps2c_oe=1 stretch.
    always @(negedge clk) begin
        if (bus.tx_done) done_cnt++;
        if (ps2c_oe) oe_run++;
        else begin
            if (oe_run != 0) last_run = oe_run;
            oe_run = 0;
        end
    end

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task host_send(input logic [7:0] d);
        int n;
        n = 0;
        while (!bus.tx_ready && n < 1000) begin @(negedge clk); n++; end
        check("ready_before_send", bus.tx_ready, 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("busy_after_accept", bus.busy, 1);
        check("c_oe_after_accept", ps2c_oe, 1);
        check("err_cleared", bus.tx_error, 0);
    endtask

    task wait_done(input string tag, input logic exp_err);
        int n;
        n = 0;
        while (!bus.tx_done && n < 20000) begin @(negedge clk); n++; end
        check({tag, "_done_seen"}, bus.tx_done, 1);
        if (bus.tx_done) begin
            check({tag, "_ready_low_at_done"}, bus.tx_ready, 0);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, bus.tx_done, 0);
            check({tag, "_ready_after_done"}, bus.tx_ready, 1);
            check({tag, "_error"}, bus.tx_error, exp_err);
            check({tag, "_oe_released"}, {ps2c_oe, ps2d_oe}, 0);
        end
    endtask

    // Device model: wait for the host request, then produce n_falls clocks.
    task dev_xfer(input int n_falls, input logic do_ack, output logic [10:0] b);
        int n;
        b = '1;
        n = 0;
        while (ps2c_line && n < 2000) begin @(negedge clk); n++; end
        n = 0;
        while (!(ps2c_line && !ps2d_line) && n < 8000) begin @(negedge clk); n++; end
        check("dev_start_seen", (n < 8000), 1);
        repeat (20) @(negedge clk);
        for (int k = 0; k < n_falls; k++) begin
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            b[k] = ps2d_line;
            if (k == 9 && do_ack) dev_d_low = 1'b1;
            if (k == 10) dev_d_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_d_low = 1'b0;
    endtask

    initial begin
        #10000000;
        $display("FAIL global_watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_oe", {ps2c_oe, ps2d_oe}, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.tx_done, 0);
        check("rst_error", bus.tx_error, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.tx_ready, 1);

        // 0xED acked: frame {ack=0, stop=1, parity=1, data}
        base = done_cnt;
        fork
            dev_xfer(11, 1'b1, bits);
            begin host_send(8'hED); wait_done("ed", 1'b0); end
        join
        check("ed_frame", bits, {1'b0, 1'b1, 1'b1, 8'hED});
        check("ed_done_count", done_cnt - base, 1);

        // 0x01 without ack: parity 0, ack line stays high
        base = done_cnt;
        fork
            dev_xfer(11, 1'b0, bits);
            begin host_send(8'h01); wait_done("noack", 1'b1); end
        join
        check("noack_frame", bits, {1'b1, 1'b1, 1'b0, 8'h01});
        check("noack_done_count", done_cnt - base, 1);

        // 0x00: parity 1, clock held low for 5000+16 cycles
        fork
            dev_xfer(11, 1'b1, bits);
            begin host_send(8'h00); wait_done("zero", 1'b0); end
        join
        check("zero_frame", bits, {1'b0, 1'b1, 1'b1, 8'h00});
        check("zero_c_low_time", last_run, 5016);

        // tx_valid held with data changed mid-transfer
        base = done_cnt;
        fork
            begin dev_xfer(11, 1'b1, bits); dev_xfer(11, 1'b1, bits2); end
            begin
                bus.tx_data  = 8'h12;
                bus.tx_valid = 1'b1;
                @(negedge clk);
                check("hold_busy", bus.busy, 1);
                repeat (2000) @(negedge clk);
                bus.tx_data = 8'h34;
                wait_done("hold1", 1'b0);
                @(negedge clk);
                check("hold_second_start", bus.busy, 1);
                bus.tx_valid = 1'b0;
                wait_done("hold2", 1'b0);
            end
        join
        check("hold_frame1", bits, {1'b0, 1'b1, 1'b1, 8'h12});
        check("hold_frame2", bits2, {1'b0, 1'b1, 1'b0, 8'h34});
        check("hold_done_count", done_cnt - base, 2);

        // reset after the 4th device falling edge
        fork
            dev_xfer(4, 1'b1, bits);
            host_send(8'h00);
        join
        repeat (20) @(negedge clk);
        base = done_cnt;
        check("midrst_d_driven", ps2d_oe, 1);
        check("midrst_busy_before", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_oe_released", {ps2c_oe, ps2d_oe}, 0);
        check("midrst_busy_after", bus.busy, 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_no_done", done_cnt - base, 0);

        // 0xFF after the aborted transfer
        fork
            dev_xfer(11, 1'b1, bits);
            begin host_send(8'hFF); wait_done("ff", 1'b0); end
        join
        check("ff_frame", bits, {1'b0, 1'b1, 1'b1, 8'hFF});

        // silent device
        base = done_cnt;
        host_send(8'h5A);
`ifdef PS2_TX_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (!bus.tx_done && n < TMO + 200) begin @(negedge clk); n++; end
            check("tmo_latency", n, TMO);
            check("tmo_error", bus.tx_error, 1);
            check("tmo_oe_released", {ps2c_oe, ps2d_oe}, 0);
        end
`else
        repeat (12000) @(negedge clk);
        check("silent_busy", bus.busy, 1);
        check("silent_no_done", done_cnt - base, 0);
        check("silent_c_released", ps2c_oe, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
